// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bus: ALU and load requesters, the load-issue tap, the register-file
// write port and the pending-load mask. The arbiter connects through the slave modport.
interface regfile_wb_arbiter_if;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        rf_we;
  logic [4:0]  rf_wr_address;
  logic [31:0] rf_wr_value;
  logic [31:0] busy_mask;

  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, issue_valid, issue_rd,
    input  alu_ready, mem_ready, rf_we, rf_wr_address, rf_wr_value, busy_mask
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, issue_valid, issue_rd,
    output alu_ready, mem_ready, rf_we, rf_wr_address, rf_wr_value, busy_mask
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter: ALU-first fixed priority with a load anti-starvation
// counter. Define WB_SCOREBOARD_EN to add the pending-load busy_mask scoreboard.
module regfile_wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input logic                 clk,
  input logic                 reset,
  regfile_wb_arbiter_if.slave bus
);
  localparam logic [2:0] LIMIT_C = 3'(STARVE_LIMIT);

  logic [2:0]  starve_cnt_r;
  logic [2:0]  starve_nxt_s;
  logic        grant_alu_s;
  logic        grant_mem_s;
  logic        xfer_s;
  logic [4:0]  win_rd_s;
  logic [31:0] win_data_s;
  logic        rf_we_r;
  logic [4:0]  rf_addr_r;
  logic [31:0] rf_val_r;

  // Grant selection; ready is forced low during reset so nothing is accepted then
  always_comb begin
    grant_alu_s = 1'b0;
    grant_mem_s = 1'b0;
    if (reset) begin
      grant_alu_s = 1'b0;
      grant_mem_s = 1'b0;
    end else if (bus.alu_valid && bus.mem_valid) begin
      if (starve_cnt_r == LIMIT_C) begin
        grant_mem_s = 1'b1;
      end else begin
        grant_alu_s = 1'b1;
      end
    end else begin
      grant_alu_s = bus.alu_valid;
      grant_mem_s = bus.mem_valid;
    end
  end

  assign bus.alu_ready = grant_alu_s;
  assign bus.mem_ready = grant_mem_s;
  assign xfer_s        = grant_alu_s || grant_mem_s;

  // Winner mux and saturating starvation counter update
  always_comb begin
    win_rd_s     = bus.alu_rd;
    win_data_s   = bus.alu_data;
    starve_nxt_s = starve_cnt_r;
    if (grant_mem_s) begin
      win_rd_s   = bus.mem_rd;
      win_data_s = bus.mem_data;
    end else begin
      win_rd_s   = bus.alu_rd;
      win_data_s = bus.alu_data;
    end
    if (grant_mem_s) begin
      starve_nxt_s = 3'd0;
    end else if (bus.mem_valid && (starve_cnt_r < LIMIT_C)) begin
      starve_nxt_s = starve_cnt_r + 3'd1;
    end else begin
      starve_nxt_s = starve_cnt_r;
    end
  end

  // Registered write port; x0 writes are accepted but never pulse rf_we
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt_r <= 3'd0;
      rf_we_r      <= 1'b0;
      rf_addr_r    <= 5'd0;
      rf_val_r     <= 32'd0;
    end else begin
      starve_cnt_r <= starve_nxt_s;
      rf_we_r      <= xfer_s && (win_rd_s != 5'd0);
      if (xfer_s) begin
        rf_addr_r <= win_rd_s;
        rf_val_r  <= win_data_s;
      end
    end
  end

  assign bus.rf_we         = rf_we_r;
  assign bus.rf_wr_address = rf_addr_r;
  assign bus.rf_wr_value   = rf_val_r;

`ifdef WB_SCOREBOARD_EN
  logic [31:0] busy_r;
  logic [31:0] busy_set_s;
  logic [31:0] busy_clr_s;

  // Set/clear vectors; the set is applied after the clear so a same-cycle issue wins
  always_comb begin
    busy_set_s = 32'd0;
    busy_clr_s = 32'd0;
    if (bus.issue_valid && (bus.issue_rd != 5'd0)) begin
      busy_set_s = 32'd1 << bus.issue_rd;
    end else begin
      busy_set_s = 32'd0;
    end
    if (grant_mem_s) begin
      busy_clr_s = 32'd1 << bus.mem_rd;
    end else begin
      busy_clr_s = 32'd0;
    end
  end

  // Pending-load scoreboard register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_r <= 32'd0;
    end else begin
      busy_r <= (busy_r & ~busy_clr_s) | busy_set_s;
    end
  end

  assign bus.busy_mask = busy_r;
`else
  logic unused_issue_s;
  assign unused_issue_s = ^{bus.issue_valid, bus.issue_rd};
  assign bus.busy_mask  = 32'd0;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: vector table, hand sequences for
// scoreboard and async reset, then constrained-random traffic against a reference model.
module tb_regfile_wb_arbiter;
  localparam int LIM = 3;

  logic clk;
  logic reset;
  regfile_wb_arbiter_if bus();

  regfile_wb_arbiter #(.STARVE_LIMIT(LIM)) dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        alu_v;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        mem_v;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        iss_v;
    logic [4:0]  iss_rd;
    logic        e_alu_rdy;
    logic        e_mem_rdy;
    logic        e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
  } vec_t;

  vec_t vecs[10];

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int          m_starve;
  logic        m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_val;
  logic [31:0] m_busy;
  logic        g_alu;
  logic        g_mem;
  logic        alu_hold;
  logic        mem_hold;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_starve = 0;
    m_we     = 1'b0;
    m_addr   = 5'd0;
    m_val    = 32'd0;
    m_busy   = 32'd0;
  endtask

  task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                       input logic iv, input logic [4:0] ird);
    bus.alu_valid = av;  bus.alu_rd = ard; bus.alu_data = ad;
    bus.mem_valid = mv;  bus.mem_rd = mrd; bus.mem_data = md;
    bus.issue_valid = iv; bus.issue_rd = ird;
  endtask

  // Settle inputs, predict grants from the rules and compare the ready outputs.
  task automatic pre_edge();
    #1;
    if (bus.alu_valid && bus.mem_valid) begin
      g_mem = (m_starve >= LIM);
      g_alu = !g_mem;
    end else begin
      g_alu = bus.alu_valid;
      g_mem = bus.mem_valid;
    end
    chk("alu_ready", 32'(bus.alu_ready), 32'(g_alu));
    chk("mem_ready", 32'(bus.mem_ready), 32'(g_mem));
  endtask

  // Advance the model across one clock edge and compare registered outputs.
  task automatic post_edge();
    logic [4:0]  rd;
    logic [31:0] data;
    @(posedge clk);
    if (g_alu || g_mem) begin
      rd   = g_mem ? bus.mem_rd : bus.alu_rd;
      data = g_mem ? bus.mem_data : bus.alu_data;
      m_we   = (rd != 5'd0);
      m_addr = rd;
      m_val  = data;
    end else begin
      m_we = 1'b0;
    end
    if (bus.mem_valid) begin
      if (g_mem) m_starve = 0;
      else if (m_starve < LIM) m_starve = m_starve + 1;
    end
`ifdef WB_SCOREBOARD_EN
    if (g_mem) m_busy[bus.mem_rd] = 1'b0;
    if (bus.issue_valid && bus.issue_rd != 5'd0) m_busy[bus.issue_rd] = 1'b1;
`endif
    #1;
    chk("rf_we", 32'(bus.rf_we), 32'(m_we));
    chk("rf_wr_address", 32'(bus.rf_wr_address), 32'(m_addr));
    chk("rf_wr_value", bus.rf_wr_value, m_val);
    chk("busy_mask", bus.busy_mask, m_busy);
  endtask

  initial begin
    vecs[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,    1'b1, 5'd9, 1'b1, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF};
    vecs[1] = '{1'b1, 5'd3, 32'h101,      1'b1, 5'd7, 32'h1234, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 32'h101};
    vecs[2] = '{1'b1, 5'd3, 32'h102,      1'b1, 5'd7, 32'h1234, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 32'h102};
    vecs[3] = '{1'b1, 5'd3, 32'h103,      1'b1, 5'd7, 32'h1234, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 32'h103};
    vecs[4] = '{1'b1, 5'd3, 32'h104,      1'b1, 5'd7, 32'h1234, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd7, 32'h1234};
    vecs[5] = '{1'b1, 5'd3, 32'h105,      1'b1, 5'd7, 32'h1234, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 32'h105};
    vecs[6] = '{1'b1, 5'd0, 32'hFFFF,     1'b1, 5'd7, 32'h1234, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'hFFFF};
    vecs[7] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 32'h99,   1'b1, 5'd9, 1'b0, 1'b1, 1'b1, 5'd9, 32'h99};
    vecs[8] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd9, 32'h99};
    vecs[9] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 32'h55,   1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h55};

    // reset state: ready must stay low even with both requesters valid
    reset = 1'b1;
    drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2, 1'b1, 5'd3);
    model_reset();
    #1;
    chk("reset_alu_ready", 32'(bus.alu_ready), 32'd0);
    chk("reset_mem_ready", 32'(bus.mem_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rf_we", 32'(bus.rf_we), 32'd0);
    chk("reset_rf_wr_address", 32'(bus.rf_wr_address), 32'd0);
    chk("reset_rf_wr_value", bus.rf_wr_value, 32'd0);
    chk("reset_busy_mask", bus.busy_mask, 32'd0);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    #2 reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].alu_v, vecs[i].alu_rd, vecs[i].alu_data, vecs[i].mem_v,
            vecs[i].mem_rd, vecs[i].mem_data, vecs[i].iss_v, vecs[i].iss_rd);
      pre_edge();
      chk($sformatf("vec%0d_alu_ready", i), 32'(bus.alu_ready), 32'(vecs[i].e_alu_rdy));
      chk($sformatf("vec%0d_mem_ready", i), 32'(bus.mem_ready), 32'(vecs[i].e_mem_rdy));
      post_edge();
      chk($sformatf("vec%0d_rf_we", i), 32'(bus.rf_we), 32'(vecs[i].e_we));
      chk($sformatf("vec%0d_rf_wr_address", i), 32'(bus.rf_wr_address), 32'(vecs[i].e_addr));
      chk($sformatf("vec%0d_rf_wr_value", i), bus.rf_wr_value, vecs[i].e_data);
    end

`ifdef WB_SCOREBOARD_EN
    // scoreboard: clear r9 left over from the table, then set, clear, and set-wins-over-clear
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h9, 1'b0, 5'd0);
    pre_edge(); post_edge();
    chk("sb_clear_old", bus.busy_mask, 32'h0);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9);
    pre_edge(); post_edge();
    chk("sb_set_r9", bus.busy_mask, 32'h00000200);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'hAB, 1'b0, 5'd0);
    pre_edge(); post_edge();
    chk("sb_clear_r9", bus.busy_mask, 32'h0);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9);
    pre_edge(); post_edge();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'hCD, 1'b1, 5'd9);
    pre_edge(); post_edge();
    chk("sb_set_wins", bus.busy_mask, 32'h00000200);
`endif

    // asynchronous reset mid-cycle with an rf_we pulse pending
    drive(1'b1, 5'd12, 32'hCAFE0001, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4);
    pre_edge();
    post_edge();
    chk("pre_reset_rf_we", 32'(bus.rf_we), 32'd1);
    drive(1'b1, 5'd13, 32'hCAFE0002, 1'b1, 5'd14, 32'h3, 1'b1, 5'd4);
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("areset_rf_we", 32'(bus.rf_we), 32'd0);
    chk("areset_rf_wr_address", 32'(bus.rf_wr_address), 32'd0);
    chk("areset_rf_wr_value", bus.rf_wr_value, 32'd0);
    chk("areset_busy_mask", bus.busy_mask, 32'd0);
    chk("areset_alu_ready", 32'(bus.alu_ready), 32'd0);
    chk("areset_mem_ready", 32'(bus.mem_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("areset_hold_rf_we", 32'(bus.rf_we), 32'd0);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    reset = 1'b0;

    // random traffic; a refused requester keeps rd/data stable until accepted
    alu_hold = 1'b0;
    mem_hold = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!alu_hold) begin
        bus.alu_valid = ($urandom_range(0, 3) != 0);
        bus.alu_rd    = 5'($urandom);
        bus.alu_data  = $urandom;
      end
      if (!mem_hold) begin
        bus.mem_valid = ($urandom_range(0, 2) != 0);
        bus.mem_rd    = 5'($urandom);
        bus.mem_data  = $urandom;
      end
      bus.issue_valid = ($urandom_range(0, 1) != 0);
      bus.issue_rd    = 5'($urandom);
      pre_edge();
      post_edge();
      alu_hold = bus.alu_valid && !g_alu;
      mem_hold = bus.mem_valid && !g_mem;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
